// File: rtl/reaction_seq_ctrl.sv
// Reaction-timer sequencer. It runs a pseudo-random pre-stimulus wait, lights the LED,
// then counts the response in ms and latches the outcome: valid, early or timeout.
module reaction_seq_ctrl #(
  parameter int TICK_DIV    = 100000,
  parameter int MIN_WAIT_MS = 2000,
  parameter int WAIT_BITS   = 13,
  parameter int TIMEOUT_MS  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic        led,
  output logic [13:0] ms_count,
  output logic [13:0] result,
  output logic        done,
  output logic        cheat,
  output logic        timeout,
  output logic [1:0]  disp_sel
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STIM, S_DONE} state_t;

  state_t        state, state_n;
  logic [15:0]   lfsr, lfsr_n;
  logic [PW-1:0] presc, presc_n;
  logic          tick;
  logic [13:0]   wait_cnt, wait_cnt_n, wait_target, wait_target_n;
  logic [13:0]   ms_count_n, result_n;
  logic          led_n, done_n, cheat_n, timeout_n;
  logic [1:0]    disp_sel_n;

  assign tick   = (presc == PW'(TICK_DIV - 1));
  // Taps 16,14,13,11 in right-shift form; a nonzero seed never reaches zero
  assign lfsr_n = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      lfsr        <= 16'hACE1;
      presc       <= '0;
      wait_cnt    <= '0;
      wait_target <= '0;
      ms_count    <= '0;
      result      <= '0;
      led         <= 1'b0;
      done        <= 1'b0;
      cheat       <= 1'b0;
      timeout     <= 1'b0;
      disp_sel    <= 2'd0;
    end else begin
      state       <= state_n;
      lfsr        <= lfsr_n;
      presc       <= presc_n;
      wait_cnt    <= wait_cnt_n;
      wait_target <= wait_target_n;
      ms_count    <= ms_count_n;
      result      <= result_n;
      led         <= led_n;
      done        <= done_n;
      cheat       <= cheat_n;
      timeout     <= timeout_n;
      disp_sel    <= disp_sel_n;
    end
  end

  always_comb begin
    state_n       = state;
    presc_n       = tick ? '0 : presc + 1'b1;
    wait_cnt_n    = wait_cnt;
    wait_target_n = wait_target;
    ms_count_n    = ms_count;
    result_n      = result;
    led_n         = led;
    done_n        = done;
    cheat_n       = cheat;
    timeout_n     = timeout;
    disp_sel_n    = disp_sel;
    if (clear) begin
      state_n    = S_IDLE;
      ms_count_n = '0;
      result_n   = '0;
      led_n      = 1'b0;
      done_n     = 1'b0;
      cheat_n    = 1'b0;
      timeout_n  = 1'b0;
      disp_sel_n = 2'd0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state_n       = S_WAIT;
          disp_sel_n    = 2'd1;
          wait_target_n = 14'(MIN_WAIT_MS) + 14'(lfsr[WAIT_BITS-1:0]);
          wait_cnt_n    = '0;
          presc_n       = '0;
        end
        S_WAIT: if (stop) begin
          state_n    = S_DONE;
          result_n   = 14'd9999;
          cheat_n    = 1'b1;
          done_n     = 1'b1;
          led_n      = 1'b0;
          disp_sel_n = 2'd2;
        end else if (tick) begin
          wait_cnt_n = wait_cnt + 14'd1;
          if (wait_cnt + 14'd1 == wait_target) begin
            state_n    = S_STIM;
            ms_count_n = '0;
            led_n      = 1'b1;
            disp_sel_n = 2'd2;
            presc_n    = '0;
          end
        end
        // stop beats a coincident tick, so the partial ms is never counted
        S_STIM: if (stop) begin
          state_n  = S_DONE;
          result_n = ms_count;
          done_n   = 1'b1;
          led_n    = 1'b0;
        end else if (tick) begin
          ms_count_n = ms_count + 14'd1;
          if (ms_count + 14'd1 == 14'(TIMEOUT_MS)) begin
            state_n   = S_DONE;
            result_n  = 14'(TIMEOUT_MS);
            timeout_n = 1'b1;
            done_n    = 1'b1;
            led_n     = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_seq_ctrl.sv
// Bench for reaction_seq_ctrl. Directed runs push the expected outcome into a queue.
// A monitor pops that outcome and compares it on each rising edge of done.
module tb_reaction_seq_ctrl;
  localparam int TD = 4, MW = 2, WB = 2, TO = 5;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic        led, done, cheat, timeout;
  logic [13:0] ms_count, result;
  logic [1:0]  disp_sel;

  reaction_seq_ctrl #(.TICK_DIV(TD), .MIN_WAIT_MS(MW), .WAIT_BITS(WB), .TIMEOUT_MS(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .led(led), .ms_count(ms_count), .result(result), .done(done),
    .cheat(cheat), .timeout(timeout), .disp_sel(disp_sel)
  );

  always #5 clk = ~clk;

  typedef struct {int res; int cht; int tmo;} exp_t;
  exp_t q[$];
  exp_t m_e;
  int passed = 0, total = 0;
  int c, wt;
  logic dq = 1'b0;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic exp_t mk(input int r, input int ch, input int tm);
    exp_t e;
    e.res = r; e.cht = ch; e.tmo = tm;
    return e;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= step(m_lfsr);

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
  endtask

  // Monitor: scoreboard compare on each done rising edge
  initial forever begin
    @(negedge clk);
    if (!rst && done && !dq) begin
      if (q.size() == 0) chk("sb_unexpected_done", q.size(), 1);
      else begin
        m_e = q.pop_front();
        chk("sb_result", int'(result), m_e.res);
        chk("sb_cheat", int'(cheat), m_e.cht);
        chk("sb_timeout", int'(timeout), m_e.tmo);
        chk("sb_led_off", int'(led), 0);
      end
    end
    dq = done;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_led(output int n);
    n = 0;
    while (!led && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("led_rise_bound", int'(led), 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_led"}, int'(led), 0);
    chk({tag, "_ms"}, int'(ms_count), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cheat"}, int'(cheat), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_disp"}, int'(disp_sel), 0);
  endtask

  initial begin
    cyc(2);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hold_disp", int'(disp_sel), 0);

    // Asynchronous reset in the middle of STIM
    pulse_start;
    wait_led(c);
    cyc(3);
    #1 rst = 1'b1;
    #1;
    chk("arst_led", int'(led), 0);
    chk("arst_result", int'(result), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_disp", int'(disp_sel), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_idle_disp", int'(disp_sel), 0);

    // Normal run with lfsr[1:0]==2, so the wait is 4 ms = 16 cycles
    c = 0;
    while (m_lfsr[1:0] != 2'd2 && c < 64) begin
      @(negedge clk);
      c++;
    end
    chk("lfsr_pick", int'(m_lfsr[1:0]), 2);
    wt = MW + int'(m_lfsr[1:0]);
    pulse_start;
    chk("wait_disp", int'(disp_sel), 1);
    chk("wait_led", int'(led), 0);
    wait_led(c);
    chk("stim_latency", c, wt * TD);
    chk("stim_disp", int'(disp_sel), 2);
    c = 0;
    while (ms_count != 14'd3 && c < 100) begin
      @(negedge clk);
      c++;
    end
    q.push_back(mk(3, 0, 0));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("normal_done", int'(done), 1);

    // start in DONE is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("done_start_disp", int'(disp_sel), 2);
    chk("done_start_done", int'(done), 1);
    chk("done_start_result", int'(result), 3);
    chk("done_frozen_ms", int'(ms_count), 3);
    do_clear;
    chk_idle("clear1");

    // Early press during WAIT
    pulse_start;
    cyc(2);
    q.push_back(mk(9999, 0 + 1, 0));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    cyc(wt * TD + 4);
    chk("early_led_stays_off", int'(led), 0);
    chk("early_done_held", int'(done), 1);
    do_clear;
    chk_idle("clear2");

    // Timeout: led high for TO*TD cycles, then DONE
    q.push_back(mk(TO, 0, 1));
    pulse_start;
    wait_led(c);
    c = 1;
    while (led && c < 100) begin
      @(negedge clk);
      if (led) c++;
    end
    chk("led_high_cycles", c, TO * TD);
    chk("timeout_ms", int'(ms_count), TO);
    chk("timeout_done", int'(done), 1);
    do_clear;

    // stop coinciding with the 2nd tick of STIM
    pulse_start;
    wait_led(c);
    cyc(7);
    chk("coll_ms_before", int'(ms_count), 1);
    q.push_back(mk(1, 0, 0));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("coll_ms_after", int'(ms_count), 1);
    do_clear;

    // stop and clear in the same cycle: clear wins
    pulse_start;
    cyc(1);
    stop = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    clear = 1'b0;
    chk_idle("stop_clear");
    cyc(3);
    chk("sb_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reaction_seq_ctrl.md
# reaction_seq_ctrl

Sequencing controller for the reaction-timer game. It turns the debounced start, stop and clear pulses into a timed test: a pseudo-random wait, then a stimulus LED, then millisecond counting of the player's response. It also classifies the outcome as valid, early (cheat) or timeout. It sits between the button debouncers and the display/LED drivers inside the reaction-timer top level.

## Interface
Parameters:
- TICK_DIV, 100000: clk cycles per 1 ms tick (100 MHz clk).
- MIN_WAIT_MS, 2000: fixed part of the pre-stimulus wait.
- WAIT_BITS, 13: number of LFSR bits added to the wait (0..2^WAIT_BITS-1 ms).
- TIMEOUT_MS, 1000: response limit; must be ≤ 9998.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse, debounced
- stop  in  1  single-cycle pulse, debounced
- clear  in  1  single-cycle pulse, debounced
- led  out  1  stimulus LED
- ms_count  out  14  live response count (ms)
- result  out  14  latched outcome (ms, or 9999)
- done  out  1  result valid
- cheat  out  1  stop arrived before stimulus
- timeout  out  1  no stop within TIMEOUT_MS
- disp_sel  out  2  0 = greeting, 1 = blank, 2 = show count/result

## Operation
- States: IDLE, WAIT, STIM, DONE. All outputs are registered.
- Same-cycle input priority: clear > stop > start.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset.
  - Steps every cycle in every state and never reaches zero.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick pulses on the TICK_DIV-1 cycle.
  - Zeroed on entry to WAIT and to STIM, so the first tick comes exactly TICK_DIV cycles after entry.
- IDLE (disp_sel=0, led=0):
  - start → WAIT.
  - Latch wait_target = MIN_WAIT_MS + lfsr[WAIT_BITS-1:0], using the LFSR value in the start cycle.
  - Zero wait_cnt.
- WAIT (disp_sel=1):
  - Each tick increments wait_cnt.
  - stop → DONE with result=9999, cheat=1.
  - When wait_cnt == wait_target (compare after increment) → STIM: ms_count=0, led=1.
- STIM (disp_sel=2, led=1):
  - Each tick increments ms_count.
  - stop → DONE with result=ms_count. If stop and tick coincide, stop wins and the increment is dropped.
  - When ms_count reaches TIMEOUT_MS → DONE with result=TIMEOUT_MS, timeout=1.
- DONE (disp_sel=2, led=0, done=1):
  - Holds result and flags; ms_count frozen.
  - start and stop are ignored.
  - clear → IDLE.
- clear in any state → IDLE next cycle. It zeroes ms_count, result, done, cheat, timeout and led. wait_target is don't-care.
- start in WAIT, STIM or DONE is ignored.
- Widths:
  - wait_cnt and wait_target are 14 bits (max 2000+8191 fits).
  - ms_count and result are 14 bits unsigned; ms_count never exceeds TIMEOUT_MS.

## Timing
- Reset (async, any time, including mid-test) sets: state=IDLE, led=0, ms_count=0, result=0, done=0, cheat=0, timeout=0, disp_sel=0, LFSR=16'hACE1, prescaler=0.
- start registered at cycle T → state=WAIT and disp_sel=1 at T+1.
- Stimulus: led rises exactly (wait_target × TICK_DIV) cycles after entering WAIT.
- stop at cycle T in STIM → led=0, done=1 and result valid at T+1. result equals the number of ticks completed before T.
- Timeout: done rises the cycle after the tick that brings ms_count to TIMEOUT_MS.
- clear at T → all outputs at IDLE values at T+1.
- Pulses longer than one cycle are not supported. A multi-cycle start is treated as one start; a multi-cycle stop is harmless.

## Test plan
Bench parameters: TICK_DIV=4, MIN_WAIT_MS=2, WAIT_BITS=2, TIMEOUT_MS=5.
- Reset check: assert rst mid-STIM → led=0, result=0, done=0, disp_sel=0 immediately (asynchronously). After release, an idle cycle with start=0 keeps state IDLE.
- Normal run: start with lfsr[1:0]=2 (bench tracks the LFSR model) → led rises 16 cycles after WAIT entry. stop after 3 ticks → result=3, done=1, cheat=0, timeout=0.
- Early press: start, then stop during WAIT → result=9999, cheat=1, led never rises. clear → IDLE, all flags 0.
- Timeout: start, no stop → led high for 20 cycles, then done=1, result=5, timeout=1, led=0.
- Collisions:
  - stop coinciding with the 2nd tick → result=1.
  - stop+clear in the same cycle → IDLE, done=0.
  - start in DONE → ignored.
